// File: rtl/wb_pipelined_ram.sv
// Pipelined Wishbone B4 responder over a word-addressed RAM: one request per
// cycle, in-order acks after LATENCY cycles, stall once MAX_OUTSTANDING pending.
module wb_pipelined_ram #(
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  input  logic        wb_cyc_i,
  output logic        wb_stall_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [AW-1:0]             idx;
  logic [31:0]               rd_word;
  logic                      accept;
  logic                      ack_int;
  logic [CW-1:0]             cnt;
  logic [LATENCY:1]          vld_pipe;
  logic [LATENCY:1][31:0]    dat_pipe;
  logic                      unused_adr;

  assign idx        = wb_adr_i[AW+1:2];
  assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

  // Stall depends only on the registered count, never on the bus inputs.
  assign wb_stall_o = (cnt == CW'(MAX_OUTSTANDING));
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign ack_int    = vld_pipe[LATENCY] & wb_cyc_i;
  assign wb_ack_o   = ack_int;
  assign wb_dat_o   = ack_int ? dat_pipe[LATENCY] : '0;

  // One byte-wide array per lane so each sel bit gates its own write port.
  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
      if (accept && !rst_i && wb_we_i && wb_sel_i[b])
        mem[idx] <= wb_dat_i[8*b +: 8];
    end

    assign rd_word[8*b +: 8] = mem[idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !wb_cyc_i) begin
      vld_pipe <= '0;
      cnt      <= '0;
    end else begin
      vld_pipe[1] <= accept;
      for (int s = 2; s <= LATENCY; s++)
        vld_pipe[s] <= vld_pipe[s-1];
      if (accept && !ack_int)
        cnt <= cnt + CW'(1);
      else if (!accept && ack_int)
        cnt <= cnt - CW'(1);
    end
  end

  // Data rides alongside the valids; writes carry zero so their ack shows 0.
  always_ff @(posedge clk_i) begin
    dat_pipe[1] <= wb_we_i ? '0 : rd_word;
    for (int s = 2; s <= LATENCY; s++)
      dat_pipe[s] <= dat_pipe[s-1];
  end
endmodule
